// File: rtl/button_scan_pkg.sv
// rtl/button_scan_pkg.sv - shared scan states and event-kind constants for the button scan arbiter
package button_scan_pkg;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

    localparam logic EV_PRESS   = 1'b1;
    localparam logic EV_RELEASE = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request arbiter with one-hot and encoded grant
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            accept,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            any
);

    logic [ID_W-1:0] last;

    // Search forward from the slot after the previous grant, wrapping once around
    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(last) + k) % N]) begin
                any = 1'b1;
                id  = ID_W'((int'(last) + k) % N);
                grant[(int'(last) + k) % N] = 1'b1;
            end
        end
    end

    // Remember the winner so the next search starts just past it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= ID_W'(N - 1);
        end else if (accept && any) begin
            last <= id;
        end
    end

endmodule

// File: rtl/button_scan_arbiter.sv
// rtl/button_scan_arbiter.sv - shared-counter button debouncer with round-robin event delivery
module button_scan_arbiter
    import button_scan_pkg::*;
#(
    parameter int N_BUTTONS     = 4,
    parameter int ID_W          = 2,
    parameter int STABLE_CYCLES = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_BUTTONS-1:0] level,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [ID_W-1:0]      ev_id,
    output logic                 ev_kind
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [ID_W-1:0]  P_LAST   = ID_W'(N_BUTTONS - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES - 1);

    logic [N_BUTTONS-1:0] sync1;
    logic [N_BUTTONS-1:0] s;
    logic [N_BUTTONS-1:0] pend;
    logic [N_BUTTONS-1:0] kind;
    logic [N_BUTTONS-1:0] commit_vec;
    logic [N_BUTTONS-1:0] grant;

    scan_state_t     state, state_nxt;
    logic [ID_W-1:0] p, p_nxt, p_adv;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            differ;
    logic            commit;

    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic            out_free;
    logic            load;

    assign p_adv      = (p == P_LAST) ? '0 : p + 1'b1;
    assign differ     = s[p] != level[p];
    assign commit_vec = commit ? (N_BUTTONS'(1) << p) : '0;
    assign out_free   = !ev_valid || ev_ready;
    assign load       = out_free && gnt_any;

    // Two-flop synchronizer on the raw asynchronous buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= button;
            s     <= sync1;
        end
    end

    // Scan FSM state, pointer and shared stability counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SCAN;
            p     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            p     <= p_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: walk the buttons, count a differing sample run, commit when settled
    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            SCAN: begin
                if (differ) begin
                    state_nxt = COUNT;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    p_nxt = p_adv;
                end
            end
            COUNT: begin
                if (differ) begin
                    if (cnt == CNT_DONE) begin
                        state_nxt = COMMIT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    p_nxt     = p_adv;
                end
            end
            COMMIT: begin
                // An undelivered event for this button blocks the commit so edges never merge
                if (!pend[p]) begin
                    commit    = 1'b1;
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    p_nxt     = p_adv;
                end
            end
            default: begin
                state_nxt = SCAN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Debounced level plus one pending event slot per button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
            kind  <= '0;
            pend  <= '0;
        end else begin
            if (commit) begin
                level[p] <= ~level[p];
                kind[p]  <= level[p] ? EV_RELEASE : EV_PRESS;
            end
            pend <= (pend & ~(load ? grant : '0)) | commit_vec;
        end
    end

    rr_arbiter #(
        .N    (N_BUTTONS),
        .ID_W (ID_W)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (pend),
        .accept (out_free),
        .grant  (grant),
        .id     (gnt_id),
        .any    (gnt_any)
    );

    // Output event register: reload when free, hold under backpressure
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_valid <= 1'b0;
            ev_id    <= '0;
            ev_kind  <= 1'b0;
        end else if (load) begin
            ev_valid <= 1'b1;
            ev_id    <= gnt_id;
            ev_kind  <= kind[gnt_id];
        end else if (ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

endmodule
